// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: debounced column-scanning keypad decoder feeding a key-code FIFO.
// Each press is debounced, scanned, verified, and pushed once; the key must be released before the next press.
module keypad_scan_fifo #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DEBOUNCE = 16,
    parameter int SETTLE   = 4,
    parameter int DEPTH    = 8,
    parameter int CW       = $clog2(ROWS * COLS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         col,
    output logic [CW-1:0]           key_code,
    output logic                    key_valid,
    input  logic                    key_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    multi_key,
    output logic                    overflow,
    input  logic                    clr_ovf
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int IW = $clog2(COLS);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, VERIFY, HOLD} state_t;

    state_t state, state_nx;
    logic [ROWS-1:0] row_m, row_s, cap, cap_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [CW-1:0] code, code_nx, hit_code;
    logic sample, deb_done, push;
    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic pop, full, wr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_m <= '0;
            row_s <= '0;
            state <= IDLE;
            cnt   <= '0;
            scnt  <= '0;
            idx   <= '0;
            code  <= '0;
            cap   <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            state <= state_nx;
            cnt   <= cnt_nx;
            scnt  <= scnt_nx;
            idx   <= idx_nx;
            code  <= code_nx;
            cap   <= cap_nx;
        end
    end

    assign sample   = state == SCAN && scnt == SW'(SETTLE - 1);
    assign deb_done = cnt == DW'(DEBOUNCE - 1);

    always_comb begin
        hit_code = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_s[r]) hit_code = CW'(r * COLS + int'(idx));
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        scnt_nx  = scnt;
        idx_nx   = idx;
        code_nx  = code;
        cap_nx   = cap;
        push     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = |row_s ? cnt + DW'(1) : '0;
                if (|row_s && deb_done) begin
                    state_nx = SCAN;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    scnt_nx  = '0;
                end
            end
            SCAN: begin
                if (!sample) begin
                    scnt_nx = scnt + SW'(1);
                end else if ($countones(row_s) == 1) begin
                    state_nx = VERIFY;
                    code_nx  = hit_code;
                    cap_nx   = row_s;
                    cnt_nx   = '0;
                end else if (|row_s) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else if (idx == IW'(COLS - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    idx_nx  = idx + IW'(1);
                    scnt_nx = '0;
                end
            end
            VERIFY: begin
                cnt_nx = cnt + DW'(1);
                if (row_s != cap) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (deb_done) begin
                    push     = 1'b1;
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            default: begin
                cnt_nx = |row_s ? '0 : cnt + DW'(1);
                if (!(|row_s) && deb_done) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    always_comb begin
        col       = (state == SCAN || state == VERIFY) ? COLS'(1) << idx : '1;
        multi_key = sample && $countones(row_s) > 1;
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign key_valid = fifo_count != '0;
    assign key_code  = key_valid ? mem[rp] : '0;
    assign pop       = key_valid && key_ready;
    assign full      = fifo_count == (AW + 1)'(DEPTH);
    assign wr        = push && (!full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wp         <= wp + AW'(wr);
            rp         <= rp + AW'(pop);
            fifo_count <= fifo_count + (AW + 1)'(wr) - (AW + 1)'(pop);
            overflow   <= (push && full && !pop) || (overflow && !clr_ovf);
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wp] <= code;
    end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: directed checks of debounce, scan, verify, hold and FIFO behaviour.
// A keypad matrix model drives row from the pressed-key map and the DUT column drive.
module tb_keypad_scan_fifo;
    logic clock, reset, key_ready, clr_ovf, key_valid, multi_key, overflow;
    logic [3:0] row, col, key_code;
    logic [2:0] fifo_count;
    logic [3:0][3:0] keys;
    int n_cmp = 0, n_bad = 0, mk_cnt = 0, scan_cycles = 0, snap;
    bit ok;

    keypad_scan_fifo #(.ROWS(4), .COLS(4), .DEBOUNCE(4), .SETTLE(3), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .fifo_count(fifo_count),
        .multi_key(multi_key), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb
        for (int r = 0; r < 4; r++) row[r] = |(keys[r] & col);

    always @(negedge clock) begin
        if (multi_key) mk_cnt++;
        if (reset && col != 4'hF) scan_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tap(input int r, input int c);
        keys[r][c] = 1'b1;
        cycles(40);
        keys = '0;
        cycles(20);
    endtask

    task automatic pop_chk(input string tag, input int exp);
        chk(tag, key_code, exp);
        key_ready = 1'b1;
        cycles(1);
        key_ready = 1'b0;
    endtask

    task automatic wait_scan(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (col != 4'hF) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0; keys = '0; key_ready = 1'b0; clr_ovf = 1'b0;
        cycles(3);
        chk("rst_col", col, 4'hF);
        chk("rst_valid", key_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_multi", multi_key, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_code", key_code, 0);
        @(negedge clock) reset = 1'b1;
        cycles(2);
        // Glitches of 2 and 3 cycles stay below the 4-cycle debounce.
        keys[0][0] = 1'b1; cycles(2); keys = '0; cycles(10);
        keys[0][0] = 1'b1; cycles(3); keys = '0; cycles(10);
        chk("short_noscan", scan_cycles, 0);
        chk("short_count", fifo_count, 0);
        keys[2][1] = 1'b1;
        cycles(40);
        chk("hold_count", fifo_count, 1);
        chk("hold_valid", key_valid, 1);
        chk("hold_code", key_code, 9);
        snap = scan_cycles;
        cycles(30);
        chk("hold_norepeat", fifo_count, 1);
        chk("hold_noscan", scan_cycles, snap);
        keys = '0; cycles(20);
        tap(2, 1);
        chk("repress_count", fifo_count, 2);
        pop_chk("pop1", 9);
        chk("pop1_count", fifo_count, 1);
        pop_chk("pop2", 9);
        chk("pop2_count", fifo_count, 0);
        key_ready = 1'b1; cycles(2); key_ready = 1'b0;
        chk("empty_pop_count", fifo_count, 0);
        chk("empty_pop_valid", key_valid, 0);
        keys[0][3] = 1'b1; keys[1][3] = 1'b1;
        cycles(40);
        chk("multi_pulses", mk_cnt, 1);
        chk("multi_nopush", fifo_count, 0);
        snap = scan_cycles;
        cycles(20);
        chk("multi_hold", scan_cycles, snap);
        chk("multi_col", col, 4'hF);
        keys = '0; cycles(20);
        tap(0, 1); tap(1, 2); tap(3, 3); tap(0, 2);
        chk("full_count", fifo_count, 4);
        chk("full_noovf", overflow, 0);
        // Fifth key: clear requested in the very cycle the drop happens.
        keys[2][0] = 1'b1;
        wait_scan(ok);
        chk("scan5_start", ok, 1);
        repeat (6) @(negedge clock);
        clr_ovf = 1'b1;
        @(posedge clock); #1;
        chk("ovf_wins_clr", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        @(negedge clock) clr_ovf = 1'b0;
        keys = '0; cycles(20);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_head", key_code, 1);
        clr_ovf = 1'b1; cycles(1); clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        keys[3][0] = 1'b1;
        wait_scan(ok);
        chk("scan6_start", ok, 1);
        repeat (6) @(negedge clock);
        key_ready = 1'b1;
        @(posedge clock); #1;
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_head", key_code, 6);
        chk("pushpop_ovf", overflow, 0);
        @(negedge clock) key_ready = 1'b0;
        keys = '0; cycles(20);
        pop_chk("drain1", 6);
        pop_chk("drain2", 15);
        pop_chk("drain3", 2);
        pop_chk("drain4", 12);
        chk("drain_count", fifo_count, 0);
        tap(1, 1);
        chk("refill_count", fifo_count, 1);
        chk("refill_code", key_code, 5);
        keys[3][0] = 1'b1;
        wait_scan(ok);
        chk("scan7_start", ok, 1);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("vrst_col", col, 4'hF);
        chk("vrst_valid", key_valid, 0);
        chk("vrst_count", fifo_count, 0);
        chk("vrst_code", key_code, 0);
        chk("vrst_multi", multi_key, 0);
        chk("vrst_ovf", overflow, 0);
        keys = '0;
        cycles(3);
        @(negedge clock) reset = 1'b1;
        cycles(30);
        chk("abort_count", fifo_count, 0);
        chk("abort_valid", key_valid, 0);
        chk("multi_total", mk_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan_fifo.md
KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Parameters
REQ-001 SHALL provide parameter ROWS, default 4, number of keypad row inputs (2..8).
REQ-002 SHALL provide parameter COLS, default 4, number of column drive outputs (2..8).
REQ-003 SHALL provide parameter DEBOUNCE, default 16, consecutive stable cycles required for press, verify and release (2..65535).
REQ-004 SHALL provide parameter SETTLE, default 4, cycles each column is driven before rows are sampled (>=3).
REQ-005 SHALL provide parameter DEPTH, default 8, key-code FIFO entries (power of two, >=2).
REQ-006 SHALL define CW = clog2(ROWS*COLS) as the code width.

Interface
REQ-007 clock  input  1  sole clock; all state updates on posedge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 row  input  ROWS  raw asynchronous keypad rows, active-high.
REQ-010 col  output  COLS  column drive, active-high.
REQ-011 key_code  output  CW  code at FIFO head.
REQ-012 key_valid  output  1  FIFO non-empty.
REQ-013 key_ready  input  1  consumer accepts head when key_valid is high.
REQ-014 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 multi_key  output  1  one-cycle pulse when >1 row is active during column sample.
REQ-016 overflow  output  1  sticky flag: a debounced key was dropped because the FIFO was full.
REQ-017 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-018 row SHALL pass through a 2-flop synchronizer (row_s); all decisions use row_s only.
REQ-019 FSM states SHALL be IDLE, SCAN, VERIFY, HOLD.
REQ-020 IDLE: col = all ones; a debounce counter counts consecutive cycles with |row_s; after DEBOUNCE cycles, go to SCAN with column index 0; any cycle with row_s==0 clears the counter.
REQ-021 SCAN: col = one-hot(index); row_s SHALL be sampled in the SETTLE-th cycle of that column.
REQ-022 SCAN sample, exactly one row bit r set: capture code = r*COLS + index, go to VERIFY.
REQ-023 SCAN sample, >1 row bit set: pulse multi_key, push nothing, go to HOLD.
REQ-024 SCAN sample, zero bits: index < COLS-1 advances index; index == COLS-1 returns to IDLE with no push (bounce).
REQ-025 VERIFY: col held; row_s SHALL equal the captured one-hot row for DEBOUNCE consecutive cycles, then push code and go to HOLD; any mismatch returns to IDLE with no push.
REQ-026 HOLD: col = all ones; go to IDLE after DEBOUNCE consecutive cycles of row_s==0; held keys SHALL NOT auto-repeat.
REQ-027 FIFO: pop on key_valid && key_ready; key_code SHALL be the head entry, first-in first-out.
REQ-028 Push when full without a same-cycle pop SHALL drop the code and set overflow; push and pop in the same cycle when full SHALL both succeed with count unchanged.
REQ-029 Pop when empty SHALL be ignored; fifo_count SHALL never exceed DEPTH or underflow.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 clr_ovf coincident with a new overflow event SHALL leave overflow set.

Reset
REQ-032 While reset is low: FSM = IDLE, counters = 0, index = 0, synchronizer = 0, FIFO empty.
REQ-033 While reset is low: col = all ones, key_valid = 0, fifo_count = 0, multi_key = 0, overflow = 0, key_code = 0.
REQ-034 Reset asserted mid-scan or mid-verify SHALL discard the in-flight code; FIFO contents SHALL be lost.
REQ-035 Reset release SHALL be synchronized externally; no state change is permitted in the first edge after release beyond normal operation.

Verification (ROWS=4, COLS=4, DEBOUNCE=4, SETTLE=3, DEPTH=4)
REQ-036 Hold key row2/col1 stable -> exactly one push, key_code = 9, key_valid high; no second push until release and a new press.
REQ-037 Row pulse shorter than 4 cycles in IDLE -> FSM stays in IDLE, fifo_count = 0.
REQ-038 Keys row0/col3 and row1/col3 together -> multi_key pulses once, no push, FSM to HOLD.
REQ-039 Five distinct keys pressed with key_ready = 0 -> fifo_count = 4, overflow = 1, FIFO holds first four codes in order; clr_ovf clears overflow.
REQ-040 FIFO full with key_ready = 1 at the same cycle as a push -> fifo_count stays 4, head advances, overflow stays 0.
REQ-041 reset low during VERIFY -> all outputs take reset values; after release, no code from the aborted press appears.
